// File: rtl/ats21_pkg.sv
// ATS21 request arbiter shared types: opcodes, status codes, mode register
// layout, client identifiers and the grant-time permission check.
package ats21_pkg;

    localparam int ATS_CMD_W  = 32;
    localparam int ATS_WORD_W = 16;

    typedef enum logic [2:0] {
        NOP       = 3'b000,
        SET_CLK   = 3'b001,
        EN_CLK    = 3'b010,
        SET_MODE  = 3'b011,
        RSVD      = 3'b100,
        SET_ALARM = 3'b101,
        SET_CDOWN = 3'b110,
        EN_AT     = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_PERM     = 2'b01,
        ST_INACTIVE = 2'b10,
        ST_ILLEGAL  = 2'b11
    } stat_e;

    typedef struct packed {
        logic       active;
        logic [1:0] at_perm;
        logic [1:0] bc_perm;
    } mode_t;

    typedef enum logic {
        CL_A = 1'b0,
        CL_B = 1'b1
    } client_e;

    localparam mode_t MODE_RESET = '{active: 1'b1, at_perm: 2'b11, bc_perm: 2'b11};

    // Status of an instruction at grant time; checks are evaluated in priority order.
    function automatic stat_e check_cmd(mode_t mode, client_e src, opcode_e op);
        stat_e st;
        st = ST_OK;
        if (!mode.active && op != SET_MODE)
            st = ST_INACTIVE;
        else if (op == NOP || op == RSVD)
            st = ST_ILLEGAL;
        else if ((op == SET_CLK || op == EN_CLK) && !mode.bc_perm[src])
            st = ST_PERM;
        else if ((op == SET_ALARM || op == SET_CDOWN || op == EN_AT) && !mode.at_perm[src])
            st = ST_PERM;
        else if (op == SET_MODE && src == CL_B)
            st = ST_PERM;
        return st;
    endfunction

endpackage

// File: rtl/ats21_rr_arb.sv
// Two-requester arbiter for the ATS21 dispatch stage.
// Build option ATS_ARB_FIXED_PRIO_EN: client A always wins a simultaneous request.
// Default build: round-robin; the pointer only moves when both clients contend,
// so a lone requester never disturbs the fairness order.
module ats21_rr_arb
    import ats21_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    req_a,
    input  logic    req_b,
    input  logic    accept,
    output logic    gnt_valid,
    output client_e gnt_src
);

    assign gnt_valid = req_a | req_b;

`ifdef ATS_ARB_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = ^{clk, reset, accept};

    // Fixed priority: A whenever it requests.
    always_comb begin
        gnt_src = req_a ? CL_A : CL_B;
    end
`else
    client_e ptr_q, ptr_d;

    // Grant selection: pointer decides only under contention.
    always_comb begin
        gnt_src = CL_A;
        if (req_a && req_b)
            gnt_src = ptr_q;
        else if (req_b)
            gnt_src = CL_B;
    end

    // Pointer moves past the winner of a contended, accepted grant.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && req_a && req_b)
            ptr_d = (gnt_src == CL_A) ? CL_B : CL_A;
    end

    // Pointer register; reset favours client A.
    always_ff @(posedge clk) begin
        if (reset)
            ptr_q <= CL_A;
        else
            ptr_q <= ptr_d;
    end
`endif

endmodule

// File: rtl/ats21_req_arbiter.sv
// ATS21 front end: captures two-word instructions from clients A and B into
// one-deep slots, arbitrates, applies the mode/permission register and issues
// one command at a time to the engine, returning per-client status pulses.
// Build option ATS_ARB_FIXED_PRIO_EN selects fixed A-over-B priority.
module ats21_req_arbiter
    import ats21_pkg::*;
#(
    parameter int CMD_W  = ATS_CMD_W,
    parameter int WORD_W = ATS_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [WORD_W-1:0] ctrlA,
    input  logic [WORD_W-1:0] ctrlB,
    output logic              ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_src,
    output logic [CMD_W-1:0]  cmd_instr,
    output logic              resp_a_valid,
    output logic              resp_b_valid,
    output logic [1:0]        stat_a,
    output logic [1:0]        stat_b,
    output logic              ovf
);

    typedef enum logic {CAP_IDLE, CAP_W1} cap_state_e;
    typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_RESP} dsp_state_e;

    cap_state_e        cap_state_q, cap_state_d;
    dsp_state_e        dsp_state_q, dsp_state_d;
    logic [WORD_W-1:0] w0a_q, w0a_d, w0b_q, w0b_d;
    logic [CMD_W-1:0]  slot_a_q, slot_a_d, slot_b_q, slot_b_d;
    logic              full_a_q, full_a_d, full_b_q, full_b_d;
    logic              ovf_q, ovf_d;
    mode_t             mode_q, mode_d;
    logic              cmd_valid_q, cmd_valid_d;
    client_e           cmd_src_q, cmd_src_d;
    logic [CMD_W-1:0]  cmd_instr_q, cmd_instr_d;
    logic              resp_a_q, resp_a_d, resp_b_q, resp_b_d;
    stat_e             stat_a_q, stat_a_d, stat_b_q, stat_b_d;

    logic              gnt_valid, accept;
    client_e           gnt_src;
    logic [CMD_W-1:0]  gnt_instr;
    opcode_e           gnt_op;
    stat_e             gnt_stat;
    logic              free_a, free_b, done;
    client_e           done_src;
    stat_e             done_stat;

    assign accept    = (dsp_state_q == D_IDLE) && gnt_valid;
    assign gnt_instr = (gnt_src == CL_B) ? slot_b_q : slot_a_q;
    assign gnt_op    = opcode_e'(gnt_instr[CMD_W-1 -: 3]);
    assign gnt_stat  = check_cmd(mode_q, gnt_src, gnt_op);

    ats21_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_a     (full_a_q),
        .req_b     (full_b_q),
        .accept    (accept),
        .gnt_valid (gnt_valid),
        .gnt_src   (gnt_src)
    );

    // Dispatch FSM: grant/check, engine handshake, one-cycle response gap.
    always_comb begin
        dsp_state_d = dsp_state_q;
        mode_d      = mode_q;
        cmd_valid_d = cmd_valid_q;
        cmd_src_d   = cmd_src_q;
        cmd_instr_d = cmd_instr_q;
        resp_a_d    = 1'b0;
        resp_b_d    = 1'b0;
        stat_a_d    = stat_a_q;
        stat_b_d    = stat_b_q;
        free_a      = 1'b0;
        free_b      = 1'b0;
        done        = 1'b0;
        done_src    = CL_A;
        done_stat   = ST_OK;
        case (dsp_state_q)
            D_IDLE: begin
                if (gnt_valid) begin
                    if (gnt_stat != ST_OK || gnt_op == SET_MODE) begin
                        done        = 1'b1;
                        done_src    = gnt_src;
                        done_stat   = gnt_stat;
                        if (gnt_stat == ST_OK)
                            mode_d = mode_t'({gnt_instr[CMD_W-4], gnt_instr[CMD_W-5 -: 2],
                                              gnt_instr[CMD_W-7 -: 2]});
                        dsp_state_d = D_RESP;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_src_d   = gnt_src;
                        cmd_instr_d = gnt_instr;
                        dsp_state_d = D_ISSUE;
                    end
                end
            end
            D_ISSUE: begin
                if (cmd_ready) begin
                    done        = 1'b1;
                    done_src    = cmd_src_q;
                    cmd_valid_d = 1'b0;
                    dsp_state_d = D_RESP;
                end
            end
            D_RESP:  dsp_state_d = D_IDLE;
            default: dsp_state_d = D_IDLE;
        endcase
        if (done) begin
            if (done_src == CL_A) begin
                free_a   = 1'b1;
                resp_a_d = 1'b1;
                stat_a_d = done_stat;
            end else begin
                free_b   = 1'b1;
                resp_b_d = 1'b1;
                stat_b_d = done_stat;
            end
        end
    end

    // Capture FSM: word0 latch, then slot write on word1; freeing a slot on the
    // same edge makes room for the incoming frame.
    always_comb begin
        cap_state_d = cap_state_q;
        w0a_d       = w0a_q;
        w0b_d       = w0b_q;
        slot_a_d    = slot_a_q;
        slot_b_d    = slot_b_q;
        full_a_d    = full_a_q & ~free_a;
        full_b_d    = full_b_q & ~free_b;
        ovf_d       = ovf_q;
        case (cap_state_q)
            CAP_IDLE: begin
                if (req) begin
                    w0a_d       = ctrlA;
                    w0b_d       = ctrlB;
                    cap_state_d = CAP_W1;
                end
            end
            CAP_W1: begin
                cap_state_d = CAP_IDLE;
                if (w0a_q[WORD_W-1 -: 3] != NOP) begin
                    if (full_a_d) begin
                        ovf_d = 1'b1;
                    end else begin
                        full_a_d = 1'b1;
                        slot_a_d = {w0a_q, ctrlA};
                    end
                end
                if (w0b_q[WORD_W-1 -: 3] != NOP) begin
                    if (full_b_d) begin
                        ovf_d = 1'b1;
                    end else begin
                        full_b_d = 1'b1;
                        slot_b_d = {w0b_q, ctrlB};
                    end
                end
            end
            default: cap_state_d = CAP_IDLE;
        endcase
    end

    // Control and visible output registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_state_q <= CAP_IDLE;
            dsp_state_q <= D_IDLE;
            full_a_q    <= 1'b0;
            full_b_q    <= 1'b0;
            ovf_q       <= 1'b0;
            mode_q      <= MODE_RESET;
            cmd_valid_q <= 1'b0;
            cmd_src_q   <= CL_A;
            cmd_instr_q <= '0;
            resp_a_q    <= 1'b0;
            resp_b_q    <= 1'b0;
            stat_a_q    <= ST_OK;
            stat_b_q    <= ST_OK;
        end else begin
            cap_state_q <= cap_state_d;
            dsp_state_q <= dsp_state_d;
            full_a_q    <= full_a_d;
            full_b_q    <= full_b_d;
            ovf_q       <= ovf_d;
            mode_q      <= mode_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_src_q   <= cmd_src_d;
            cmd_instr_q <= cmd_instr_d;
            resp_a_q    <= resp_a_d;
            resp_b_q    <= resp_b_d;
            stat_a_q    <= stat_a_d;
            stat_b_q    <= stat_b_d;
        end
    end

    // Instruction data registers; contents are qualified by the full flags.
    always_ff @(posedge clk) begin
        w0a_q    <= w0a_d;
        w0b_q    <= w0b_d;
        slot_a_q <= slot_a_d;
        slot_b_q <= slot_b_d;
    end

    assign ready        = (cap_state_q == CAP_IDLE) && !full_a_q && !full_b_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_src      = cmd_src_q;
    assign cmd_instr    = cmd_instr_q;
    assign resp_a_valid = resp_a_q;
    assign resp_b_valid = resp_b_q;
    assign stat_a       = stat_a_q;
    assign stat_b       = stat_b_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_ats21_req_arbiter.sv
// Directed bench for ats21_req_arbiter: reset state, dispatch timing,
// arbitration order, mode/permission checks, overflow and mid-handshake reset.
module tb_ats21_req_arbiter;

    logic        clk = 1'b0;
    logic        reset, req, cmd_ready;
    logic [15:0] ctrlA, ctrlB;
    logic        ready, cmd_valid, cmd_src;
    logic [31:0] cmd_instr;
    logic        resp_a_valid, resp_b_valid;
    logic [1:0]  stat_a, stat_b;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int n_resp_a = 0;
    int n_resp_b = 0;
    int n_cmd = 0;

    ats21_req_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .ctrlA        (ctrlA),
        .ctrlB        (ctrlB),
        .ready        (ready),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_src      (cmd_src),
        .cmd_instr    (cmd_instr),
        .resp_a_valid (resp_a_valid),
        .resp_b_valid (resp_b_valid),
        .stat_a       (stat_a),
        .stat_b       (stat_b),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (resp_a_valid) n_resp_a++;
        if (resp_b_valid) n_resp_b++;
        if (cmd_valid) n_cmd++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the word1 (E1) edge.
    task automatic send(input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] b0, input logic [15:0] b1);
        req = 1'b1; ctrlA = a0; ctrlB = b0;
        step(1);
        req = 1'b0; ctrlA = a1; ctrlB = b1;
        step(1);
        ctrlA = 16'h0; ctrlB = 16'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 1'b0; ctrlA = 16'h0; ctrlB = 16'h0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cmd_ready = 1'b1;
        do_reset();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid got %b want 0", cmd_valid); end
        checks++; if (cmd_src !== 1'b0 || cmd_instr !== 32'h0) begin errors++; $display("FAIL rst_cmd got src=%b instr=%h want 0/0", cmd_src, cmd_instr); end
        checks++; if ({resp_a_valid, resp_b_valid, stat_a, stat_b, ovf} !== 7'b0) begin errors++; $display("FAIL rst_resp got %b%b %b %b ovf=%b want all 0", resp_a_valid, resp_b_valid, stat_a, stat_b, ovf); end
    endtask

    task automatic test_single_dispatch();
        do_reset();
        send(16'h2000, 16'h0000, 16'h0000, 16'h0000);
        checks++; if (cmd_valid !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL t1_e1 got valid=%b ready=%b want 0/0", cmd_valid, ready); end
        step(1);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b want 1", cmd_valid); end
        checks++; if (cmd_src !== 1'b0 || cmd_instr !== 32'h2000_0000) begin errors++; $display("FAIL t1_cmd got src=%b instr=%h want 0/20000000", cmd_src, cmd_instr); end
        step(1);
        checks++; if (cmd_valid !== 1'b0 || resp_a_valid !== 1'b1 || stat_a !== 2'b00) begin errors++; $display("FAIL t1_resp got valid=%b resp=%b stat=%b want 0/1/00", cmd_valid, resp_a_valid, stat_a); end
        step(1);
        checks++; if (resp_a_valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL t1_after got resp=%b ready=%b want 0/1", resp_a_valid, ready); end
        step(1);
    endtask

    task automatic test_arbitration();
        logic exp_first, exp_second;
`ifdef ATS_ARB_FIXED_PRIO_EN
        exp_first = 1'b0; exp_second = 1'b1;
`else
        exp_first = 1'b1; exp_second = 1'b0;
`endif
        do_reset();
        cmd_ready = 1'b1;
        send(16'hA000, 16'h0045, 16'h2240, 16'h0000);
        step(1);
        checks++; if (cmd_valid !== 1'b1 || cmd_src !== 1'b0 || cmd_instr !== 32'hA000_0045) begin errors++; $display("FAIL t2_g1 got v=%b src=%b instr=%h want 1/0/A0000045", cmd_valid, cmd_src, cmd_instr); end
        step(1);
        checks++; if (resp_a_valid !== 1'b1 || cmd_valid !== 1'b0) begin errors++; $display("FAIL t2_r1 got resp_a=%b v=%b want 1/0", resp_a_valid, cmd_valid); end
        step(1);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL t2_gap got v=%b want 0", cmd_valid); end
        step(1);
        checks++; if (cmd_valid !== 1'b1 || cmd_src !== 1'b1 || cmd_instr !== 32'h2240_0000) begin errors++; $display("FAIL t2_g2 got v=%b src=%b instr=%h want 1/1/22400000", cmd_valid, cmd_src, cmd_instr); end
        step(1);
        checks++; if (resp_b_valid !== 1'b1 || stat_b !== 2'b00) begin errors++; $display("FAIL t2_r2 got resp_b=%b stat=%b want 1/00", resp_b_valid, stat_b); end
        step(1);
        send(16'hA000, 16'h0045, 16'h2240, 16'h0000);
        step(1);
        checks++; if (cmd_valid !== 1'b1 || cmd_src !== exp_first) begin errors++; $display("FAIL t2_g3 got v=%b src=%b want 1/%b", cmd_valid, cmd_src, exp_first); end
        step(3);
        checks++; if (cmd_valid !== 1'b1 || cmd_src !== exp_second) begin errors++; $display("FAIL t2_g4 got v=%b src=%b want 1/%b", cmd_valid, cmd_src, exp_second); end
        step(3);
    endtask

    task automatic test_permissions();
        do_reset();
        cmd_ready = 1'b1;
        // word0 0x7900: SET_MODE, active=1, at_perm=10, bc_perm=01
        send(16'h7900, 16'h0000, 16'h0000, 16'h0000);
        step(1);
        checks++; if (resp_a_valid !== 1'b1 || stat_a !== 2'b00 || cmd_valid !== 1'b0) begin errors++; $display("FAIL t3_mode got resp=%b stat=%b v=%b want 1/00/0", resp_a_valid, stat_a, cmd_valid); end
        step(2);
        send(16'h0000, 16'h0000, 16'h2000, 16'h0001);
        step(1);
        checks++; if (resp_b_valid !== 1'b1 || stat_b !== 2'b01 || cmd_valid !== 1'b0) begin errors++; $display("FAIL t3_b_clk got resp=%b stat=%b v=%b want 1/01/0", resp_b_valid, stat_b, cmd_valid); end
        step(2);
        send(16'h0000, 16'h0000, 16'hA000, 16'h0001);
        step(1);
        checks++; if (cmd_valid !== 1'b1 || cmd_src !== 1'b1 || cmd_instr !== 32'hA000_0001) begin errors++; $display("FAIL t3_b_alarm got v=%b src=%b instr=%h want 1/1/A0000001", cmd_valid, cmd_src, cmd_instr); end
        step(1);
        checks++; if (resp_b_valid !== 1'b1 || stat_b !== 2'b00) begin errors++; $display("FAIL t3_b_alarm_resp got resp=%b stat=%b want 1/00", resp_b_valid, stat_b); end
        step(2);
        send(16'hA000, 16'h0001, 16'h0000, 16'h0000);
        step(1);
        checks++; if (resp_a_valid !== 1'b1 || stat_a !== 2'b01 || cmd_valid !== 1'b0) begin errors++; $display("FAIL t3_a_alarm got resp=%b stat=%b v=%b want 1/01/0", resp_a_valid, stat_a, cmd_valid); end
        step(2);
        checks++; if (stat_a !== 2'b01 || resp_a_valid !== 1'b0) begin errors++; $display("FAIL t3_stat_hold got stat=%b resp=%b want 01/0", stat_a, resp_a_valid); end
    endtask

    task automatic test_inactive_illegal();
        int c0;
        do_reset();
        cmd_ready = 1'b1;
        c0 = n_cmd;
        send(16'h8000, 16'h0000, 16'h0000, 16'h0000);
        step(1);
        checks++; if (resp_a_valid !== 1'b1 || stat_a !== 2'b11) begin errors++; $display("FAIL t4_illegal got resp=%b stat=%b want 1/11", resp_a_valid, stat_a); end
        step(2);
        send(16'h6000, 16'h0000, 16'h0000, 16'h0000);
        step(1);
        checks++; if (resp_a_valid !== 1'b1 || stat_a !== 2'b00) begin errors++; $display("FAIL t4_mode got resp=%b stat=%b want 1/00", resp_a_valid, stat_a); end
        step(2);
        send(16'hE080, 16'h0000, 16'h0000, 16'h0000);
        step(1);
        checks++; if (resp_a_valid !== 1'b1 || stat_a !== 2'b10) begin errors++; $display("FAIL t4_inactive got resp=%b stat=%b want 1/10", resp_a_valid, stat_a); end
        step(2);
        checks++; if (n_cmd !== c0) begin errors++; $display("FAIL t4_no_cmd got %0d cmd cycles want 0", n_cmd - c0); end
    endtask

    task automatic test_overflow();
        int ra;
        do_reset();
        cmd_ready = 1'b0;
        ra = n_resp_a;
        send(16'h2000, 16'h1234, 16'h0000, 16'h0000);
        step(1);
        checks++; if (cmd_valid !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL t5_issue got v=%b ovf=%b want 1/0", cmd_valid, ovf); end
        step(3);
        send(16'h4000, 16'h5678, 16'h0000, 16'h0000);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL t5_ovf got %b want 1", ovf); end
        step(4);
        checks++; if (cmd_valid !== 1'b1 || cmd_instr !== 32'h2000_1234) begin errors++; $display("FAIL t5_stable got v=%b instr=%h want 1/20001234", cmd_valid, cmd_instr); end
        cmd_ready = 1'b1;
        step(1);
        checks++; if (cmd_valid !== 1'b0 || resp_a_valid !== 1'b1) begin errors++; $display("FAIL t5_xfer got v=%b resp=%b want 0/1", cmd_valid, resp_a_valid); end
        step(5);
        checks++; if (n_resp_a - ra !== 1 || ready !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL t5_end got resps=%0d ready=%b ovf=%b want 1/1/1", n_resp_a - ra, ready, ovf); end
    endtask

    task automatic test_reset_mid_issue();
        int ra, rb;
        do_reset();
        cmd_ready = 1'b1;
        // Restrict B from SET_CLK so the post-reset check can see the default mode.
        send(16'h7100, 16'h0000, 16'h0000, 16'h0000);
        step(3);
        cmd_ready = 1'b0;
        send(16'h2000, 16'h0000, 16'h0000, 16'h0000);
        step(2);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL t6_issue got v=%b want 1", cmd_valid); end
        ra = n_resp_a; rb = n_resp_b;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (cmd_valid !== 1'b0 || ready !== 1'b1 || resp_a_valid !== 1'b0) begin errors++; $display("FAIL t6_reset got v=%b ready=%b resp=%b want 0/1/0", cmd_valid, ready, resp_a_valid); end
        cmd_ready = 1'b1;
        step(3);
        checks++; if (n_resp_a !== ra || n_resp_b !== rb) begin errors++; $display("FAIL t6_no_resp got a=%0d b=%0d want 0/0", n_resp_a - ra, n_resp_b - rb); end
        send(16'h0000, 16'h0000, 16'h2000, 16'h0002);
        step(1);
        checks++; if (cmd_valid !== 1'b1 || cmd_src !== 1'b1) begin errors++; $display("FAIL t6_default_mode got v=%b src=%b want 1/1", cmd_valid, cmd_src); end
        step(1);
        checks++; if (resp_b_valid !== 1'b1 || stat_b !== 2'b00) begin errors++; $display("FAIL t6_b_resp got resp=%b stat=%b want 1/00", resp_b_valid, stat_b); end
        step(2);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; ctrlA = 16'h0; ctrlB = 16'h0; cmd_ready = 1'b1;
        test_reset();
        test_single_dispatch();
        test_arbitration();
        test_permissions();
        test_inactive_illegal();
        test_overflow();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
